// File: rtl/sfifo_fwft.sv
// -----------------------------------------------------------------------------
// sfifo_fwft
//   Single-clock FIFO built on an inferred block RAM with a 1-cycle registered
//   read. The FWFT parameter selects the read mode:
//     - Standard mode (FWFT=0): a pop returns the head word on dout one cycle
//       later, and valid is high in that cycle. dout holds its value otherwise.
//     - FWFT mode (FWFT=1): the RAM output register acts as a prefetch stage,
//       so the head word is already on dout whenever empty is low. rd_en pops
//       it, and the next word follows in the next cycle with no bubble.
//   The occupancy count is the single source of truth for full and the
//   almost flags. In FWFT mode it includes the prefetched word.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-high (flushes the FIFO)
//   din           write data
//   wr_en         write request; accepted when ~full
//   rd_en         read/pop request; accepted when ~empty
//   dout          read data
//   valid         standard: dout carries a word popped last cycle
//                 FWFT: equals ~empty
//   empty         no word available to read
//   full          data_count == DEPTH
//   almost_full   data_count >= AFULL_THRESH
//   almost_empty  data_count <= AEMPTY_THRESH
//   data_count    words written and not yet popped (0..DEPTH)
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module sfifo_fwft #(
  parameter int DATA_WIDTH    = 18,
  parameter int ADDR_WIDTH    = 10,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_T    = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_T    = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   ram_words;

  logic [DATA_WIDTH-1:0] dout_p1;
  logic                  vld_p1;
  logic                  ovf_p1;
  logic                  unf_p1;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  fetch;

  // Flags decode from the registered count; empty depends on the read mode
  // because in FWFT a word is only readable once it sits in the output stage.
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);
  assign empty        = (FWFT != 0) ? ~vld_p1 : (count == '0);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Words still inside the RAM, i.e. not yet moved to the output stage.
  assign ram_words = count - {{ADDR_WIDTH{1'b0}}, vld_p1};

  // Standard mode reads the RAM only on a pop. FWFT refills the output stage
  // whenever it is empty or being popped and the RAM holds a word; reading
  // while popping is what sustains one word per cycle. The fetched address
  // never equals the one being written: ram_words > 0 implies they differ.
  assign fetch = (FWFT != 0) ? ((ram_words != '0) & (~vld_p1 | rd_acc))
                             : rd_acc;

  // Storage: write port, no reset on contents.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Stage p1: registered RAM read, doubling as the FWFT prefetch register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1 <= '0;
    end else if (fetch) begin
      dout_p1 <= mem[rd_ptr];
    end
  end

  // Control: pointers, occupancy, output-stage valid and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A write while full is rejected even when a read frees a slot in the
      // same cycle, since acceptance looks only at this cycle's flags.
      ovf_p1 <= wr_en & full;
      unf_p1 <= rd_en & empty;

      if (FWFT != 0) begin
        if (fetch) begin
          vld_p1 <= 1'b1;
        end else if (rd_acc) begin
          vld_p1 <= 1'b0;
        end
      end else begin
        vld_p1 <= rd_acc;
      end
    end
  end

  assign dout       = dout_p1;
  assign valid      = vld_p1;
  assign data_count = count;
  assign overflow   = ovf_p1;
  assign underflow  = unf_p1;

endmodule

// File: tb/tb_sfifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_sfifo_fwft
//   Directed bench for sfifo_fwft at DEPTH=16, with one standard-mode instance
//   (u_std) and one FWFT instance (u_fw). Inputs change 1 time unit after a
//   rising edge and are held for that whole cycle. Outputs are sampled at the
//   same point, so each sample shows the state left by the edge just passed.
// -----------------------------------------------------------------------------
module tb_sfifo_fwft;

  localparam int DW = 18;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [DW-1:0] dout0, dout1;
  logic          valid0, empty0, full0, af0, ae0, ovf0, unf0;
  logic          valid1, empty1, full1, af1, ae1, ovf1, unf1;
  logic [AW:0]   cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sfifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
               .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_std (
    .clk(clk), .rst(rst), .din(din0), .wr_en(wr0), .rd_en(rd0),
    .dout(dout0), .valid(valid0), .empty(empty0), .full(full0),
    .almost_full(af0), .almost_empty(ae0), .data_count(cnt0),
    .overflow(ovf0), .underflow(unf0));

  sfifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
               .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_fw (
    .clk(clk), .rst(rst), .din(din1), .wr_en(wr1), .rd_en(rd1),
    .dout(dout1), .valid(valid1), .empty(empty1), .full(full1),
    .almost_full(af1), .almost_empty(ae1), .data_count(cnt1),
    .overflow(ovf1), .underflow(unf1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset, then idle.
    tick();
    tick();
    rst = 1'b0;
    chk("rst std empty", 32'(empty0), 1);
    chk("rst std full", 32'(full0), 0);
    chk("rst std aempty", 32'(ae0), 1);
    chk("rst std afull", 32'(af0), 0);
    chk("rst std count", 32'(cnt0), 0);
    chk("rst std valid", 32'(valid0), 0);
    chk("rst std dout", 32'(dout0), 0);
    chk("rst std ovf", 32'(ovf0), 0);
    chk("rst std unf", 32'(unf0), 0);
    chk("rst fw empty", 32'(empty1), 1);
    chk("rst fw valid", 32'(valid1), 0);
    chk("rst fw dout", 32'(dout1), 0);
    tick();
    chk("idle std empty", 32'(empty0), 1);

    // Standard mode: fill 16 words 1..16.
    for (int i = 1; i <= 16; i++) begin
      din0 = DW'(i);
      wr0  = 1'b1;
      tick();
      chk("fill std count", 32'(cnt0), 32'(i));
      chk("fill std empty", 32'(empty0), 0);
      chk("fill std afull", 32'(af0), (i >= 12) ? 1 : 0);
      chk("fill std aempty", 32'(ae0), (i <= 4) ? 1 : 0);
      chk("fill std full", 32'(full0), (i == 16) ? 1 : 0);
    end

    // Write while full: dropped, overflow pulses once.
    din0 = 18'h3FFFF;
    tick();
    wr0 = 1'b0;
    chk("ovf std pulse", 32'(ovf0), 1);
    chk("ovf std count", 32'(cnt0), 16);
    tick();
    chk("ovf std clear", 32'(ovf0), 0);

    // Drain 16: each word valid one cycle after its pop.
    for (int i = 1; i <= 16; i++) begin
      rd0 = 1'b1;
      tick();
      chk("drain std valid", 32'(valid0), 1);
      chk("drain std dout", 32'(dout0), 32'(i));
      chk("drain std count", 32'(cnt0), 32'(16 - i));
      chk("drain std full", 32'(full0), 0);
    end
    rd0 = 1'b0;
    chk("drain std empty", 32'(empty0), 1);
    tick();
    chk("idle std valid", 32'(valid0), 0);
    chk("idle std dout hold", 32'(dout0), 16);

    // Read while empty: underflow pulses once.
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    chk("unf std pulse", 32'(unf0), 1);
    chk("unf std valid", 32'(valid0), 0);
    chk("unf std count", 32'(cnt0), 0);
    tick();
    chk("unf std clear", 32'(unf0), 0);

    // Simultaneous read and write while full: only the read is accepted.
    wr0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din0 = DW'(32'h64 + i);
      tick();
    end
    chk("refill std full", 32'(full0), 1);
    din0 = 18'h3FFFF;
    rd0  = 1'b1;
    tick();
    wr0 = 1'b0;
    chk("rw full count", 32'(cnt0), 15);
    chk("rw full ovf", 32'(ovf0), 1);
    chk("rw full valid", 32'(valid0), 1);
    chk("rw full dout", 32'(dout0), 32'h64);
    chk("rw full cleared", 32'(full0), 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("rw drain dout", 32'(dout0), 32'(32'h64 + i));
    end
    rd0 = 1'b0;
    chk("rw drain empty", 32'(empty0), 1);

    // Standard mode, count 1 with simultaneous read and write.
    din0 = 18'h00111;
    wr0  = 1'b1;
    tick();
    din0 = 18'h00222;
    rd0  = 1'b1;
    tick();
    wr0 = 1'b0;
    chk("c1 std empty", 32'(empty0), 0);
    chk("c1 std count", 32'(cnt0), 1);
    chk("c1 std dout", 32'(dout0), 32'h111);
    tick();
    rd0 = 1'b0;
    chk("c1 std dout2", 32'(dout0), 32'h222);
    chk("c1 std empty2", 32'(empty0), 1);

    // Standard mode wrap-around: preload 10, stream 40, drain 10.
    wr0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din0 = DW'(32'h1000 + i);
      tick();
    end
    rd0 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      din0 = DW'(32'h1000 + 10 + j);
      tick();
      chk("wrap std dout", 32'(dout0), 32'(32'h1000 + j));
      chk("wrap std count", 32'(cnt0), 10);
    end
    wr0 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("wrap std tail", 32'(dout0), 32'(32'h1000 + 40 + j));
    end
    rd0 = 1'b0;
    chk("wrap std empty", 32'(empty0), 1);

    // FWFT: a single write shows on dout two cycles later.
    din1 = 18'h2A5A5;
    wr1  = 1'b1;
    tick();
    wr1 = 1'b0;
    chk("fw1 count", 32'(cnt1), 1);
    chk("fw1 still empty", 32'(empty1), 1);
    tick();
    chk("fw1 empty", 32'(empty1), 0);
    chk("fw1 valid", 32'(valid1), 1);
    chk("fw1 dout", 32'(dout1), 32'h2A5A5);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    chk("fw1 pop empty", 32'(empty1), 1);
    chk("fw1 pop count", 32'(cnt1), 0);
    chk("fw1 pop valid", 32'(valid1), 0);

    // FWFT underflow.
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    chk("unf fw pulse", 32'(unf1), 1);
    tick();
    chk("unf fw clear", 32'(unf1), 0);

    // FWFT count 1 with simultaneous read and write: one-cycle empty.
    din1 = 18'h000AA;
    wr1  = 1'b1;
    tick();
    wr1 = 1'b0;
    tick();
    chk("c1 fw head", 32'(dout1), 32'hAA);
    din1 = 18'h000BB;
    wr1  = 1'b1;
    rd1  = 1'b1;
    tick();
    wr1 = 1'b0;
    rd1 = 1'b0;
    chk("c1 fw empty", 32'(empty1), 1);
    chk("c1 fw count", 32'(cnt1), 1);
    tick();
    chk("c1 fw refill", 32'(empty1), 0);
    chk("c1 fw dout", 32'(dout1), 32'hBB);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    chk("c1 fw drained", 32'(cnt1), 0);

    // FWFT fill to full, overflow, then back-to-back pops.
    wr1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din1 = DW'(32'h300 + i);
      tick();
    end
    chk("fill fw count", 32'(cnt1), 16);
    chk("fill fw full", 32'(full1), 1);
    chk("fill fw afull", 32'(af1), 1);
    chk("fill fw aempty", 32'(ae1), 0);
    din1 = 18'h3FFFF;
    tick();
    wr1 = 1'b0;
    chk("ovf fw pulse", 32'(ovf1), 1);
    chk("ovf fw count", 32'(cnt1), 16);
    for (int i = 0; i < 16; i++) begin
      chk("stream fw dout", 32'(dout1), 32'(32'h300 + i));
      chk("stream fw valid", 32'(valid1), 1);
      rd1 = 1'b1;
      tick();
    end
    rd1 = 1'b0;
    chk("stream fw empty", 32'(empty1), 1);
    chk("stream fw count", 32'(cnt1), 0);

    // Reset mid-stream at count 7 with wr_en = rd_en = 1.
    wr0 = 1'b1;
    wr1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din0 = DW'(32'h400 + i);
      din1 = DW'(32'h400 + i);
      tick();
    end
    chk("pre-rst std count", 32'(cnt0), 7);
    chk("pre-rst fw count", 32'(cnt1), 7);
    din0 = 18'h004FF;
    din1 = 18'h004FF;
    rd0  = 1'b1;
    rd1  = 1'b1;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    wr0 = 1'b0;
    wr1 = 1'b0;
    rd0 = 1'b0;
    rd1 = 1'b0;
    chk("mrst std count", 32'(cnt0), 0);
    chk("mrst std empty", 32'(empty0), 1);
    chk("mrst std valid", 32'(valid0), 0);
    chk("mrst std dout", 32'(dout0), 0);
    chk("mrst fw count", 32'(cnt1), 0);
    chk("mrst fw empty", 32'(empty1), 1);
    chk("mrst fw valid", 32'(valid1), 0);
    tick();
    tick();
    tick();
    chk("mrst fw no stale", 32'(empty1), 1);
    chk("mrst std idle", 32'(cnt0), 0);
    din0 = 18'h00555;
    din1 = 18'h00666;
    wr0  = 1'b1;
    wr1  = 1'b1;
    tick();
    wr0 = 1'b0;
    wr1 = 1'b0;
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    chk("post-rst std dout", 32'(dout0), 32'h555);
    chk("post-rst fw dout", 32'(dout1), 32'h666);
    chk("post-rst fw count", 32'(cnt1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
